// File: rtl/img_pkg.sv
// Shared definitions for the image sequencing datapath: state codes and default widths.
package img_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/seq_addr_counter.sv
// Address counter with clear/increment and an equality flag against a supplied limit.
module seq_addr_counter #(
  parameter int ADDR_W = 10
) (
  input  logic              i_CLK,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_inc,
  input  logic [ADDR_W-1:0] i_limit,
  output logic [ADDR_W-1:0] o_cnt,
  output logic              o_at_limit
);

  logic [ADDR_W-1:0] cnt_q;

  always_ff @(posedge i_CLK) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else if (i_inc) begin
      cnt_q <= cnt_q + ADDR_W'(1);
    end
  end

  assign o_cnt      = cnt_q;
  assign o_at_limit = (cnt_q == i_limit);

endmodule

// File: rtl/conv_sequencer.sv
// Sequences image load into the image RAM, streaming to the convolution unit,
// and result capture into the result RAM.
//
// state | meaning
// IDLE  | waiting for load or run request
// LOAD  | image words from the register file written to image RAM
// RUN   | stored pixels streamed to the conv unit, results captured
// DRAIN | all pixels issued, waiting for the remaining results
// DONE  | EOP held until the next load
module conv_sequencer
  import img_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_CLK,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_load,
  input  logic              i_run,
  input  logic              i_KNorIMG,
  input  logic [ADDR_W-1:0] i_imgLength,
  input  logic [DATA_W-1:0] i_pixel,
  output logic              o_img_we,
  output logic              o_img_re,
  output logic [ADDR_W-1:0] o_img_addr,
  output logic [DATA_W-1:0] o_img_wdata,
  input  logic [DATA_W-1:0] i_img_rdata,
  input  logic              i_conv_ready,
  output logic              o_conv_valid,
  output logic [DATA_W-1:0] o_conv_data,
  input  logic              i_conv_valid,
  input  logic [DATA_W-1:0] i_conv_result,
  output logic              o_res_we,
  output logic [ADDR_W-1:0] o_res_addr,
  output logic [DATA_W-1:0] o_res_wdata,
  output logic              o_EOP,
  output logic              o_overflow,
  output logic [2:0]        o_state
);

  seq_state_e        state_q;
  logic [ADDR_W-1:0] n_q;
  logic              conv_valid_q;
  logic              overflow_q;
  logic              eop_q;

  logic [ADDR_W-1:0] wr_cnt, rd_cnt, res_cnt;
  logic              wr_full, rd_done, res_done;
  logic              wr_empty, res_last;
  logic              img_strobe, img_we, img_re, res_we;
  logic              enter_load, enter_run;

  assign wr_empty   = (wr_cnt == '0);
  assign img_strobe = (state_q == ST_LOAD) & i_valid & i_KNorIMG;
  assign img_we     = img_strobe & ~wr_full;
  assign img_re     = (state_q == ST_RUN) & i_conv_ready & ~rd_done;
  assign res_we     = i_conv_valid & ((state_q == ST_RUN) | (state_q == ST_DRAIN));
  assign enter_load = i_load & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign enter_run  = (state_q == ST_IDLE) & ~i_load & i_run & ~wr_empty;
  // A result landing this cycle may be the last one.
  assign res_last   = res_done | (res_we & ((res_cnt + ADDR_W'(1)) == wr_cnt));

  seq_addr_counter #(.ADDR_W(ADDR_W)) u_wr_cnt (
    .i_CLK(i_CLK), .i_rst(i_rst), .i_clr(enter_load), .i_inc(img_we),
    .i_limit(n_q), .o_cnt(wr_cnt), .o_at_limit(wr_full)
  );

  seq_addr_counter #(.ADDR_W(ADDR_W)) u_rd_cnt (
    .i_CLK(i_CLK), .i_rst(i_rst), .i_clr(enter_run), .i_inc(img_re),
    .i_limit(wr_cnt), .o_cnt(rd_cnt), .o_at_limit(rd_done)
  );

  seq_addr_counter #(.ADDR_W(ADDR_W)) u_res_cnt (
    .i_CLK(i_CLK), .i_rst(i_rst), .i_clr(enter_run), .i_inc(res_we),
    .i_limit(wr_cnt), .o_cnt(res_cnt), .o_at_limit(res_done)
  );

  always_ff @(posedge i_CLK) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      conv_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      eop_q        <= 1'b0;
    end else begin
      conv_valid_q <= img_re;
      if (enter_load) begin
        n_q        <= i_imgLength;
        overflow_q <= 1'b0;
        eop_q      <= 1'b0;
      end else if (img_strobe & wr_full) begin
        overflow_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (i_load) begin
            state_q <= ST_LOAD;
          end else if (i_run) begin
            if (wr_empty) begin
              state_q <= ST_DONE;
              eop_q   <= 1'b1;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_LOAD: begin
          if (!i_load) state_q <= ST_IDLE;
        end
        ST_RUN: begin
          if (rd_done) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (res_last) begin
            state_q <= ST_DONE;
            eop_q   <= 1'b1;
          end
        end
        ST_DONE: begin
          if (i_load) state_q <= ST_LOAD;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_img_we     = img_we;
  assign o_img_re     = img_re;
  assign o_img_addr   = img_we ? wr_cnt : (img_re ? rd_cnt : '0);
  assign o_img_wdata  = img_we ? i_pixel : '0;
  assign o_conv_valid = conv_valid_q;
  assign o_conv_data  = conv_valid_q ? i_img_rdata : '0;
  assign o_res_we     = res_we;
  assign o_res_addr   = res_we ? res_cnt : '0;
  assign o_res_wdata  = res_we ? i_conv_result : '0;
  assign o_EOP        = eop_q;
  assign o_overflow   = overflow_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer with an image RAM model and a 3-cycle echo conv unit.
module tb_conv_sequencer;

  localparam int DW = 8;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0, i_load = 1'b0, i_run = 1'b0, i_KNorIMG = 1'b0;
  logic [AW-1:0] i_imgLength = '0;
  logic [DW-1:0] i_pixel = '0;
  logic          o_img_we, o_img_re;
  logic [AW-1:0] o_img_addr;
  logic [DW-1:0] o_img_wdata;
  logic [DW-1:0] i_img_rdata = '0;
  logic          i_conv_ready = 1'b0;
  logic          o_conv_valid;
  logic [DW-1:0] o_conv_data;
  logic          i_conv_valid;
  logic [DW-1:0] i_conv_result;
  logic          o_res_we;
  logic [AW-1:0] o_res_addr;
  logic [DW-1:0] o_res_wdata;
  logic          o_EOP, o_overflow;
  logic [2:0]    o_state;

  always #5 clk = ~clk;

  conv_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .i_CLK(clk), .i_rst(rst), .i_valid(i_valid), .i_load(i_load), .i_run(i_run),
    .i_KNorIMG(i_KNorIMG), .i_imgLength(i_imgLength), .i_pixel(i_pixel),
    .o_img_we(o_img_we), .o_img_re(o_img_re), .o_img_addr(o_img_addr),
    .o_img_wdata(o_img_wdata), .i_img_rdata(i_img_rdata), .i_conv_ready(i_conv_ready),
    .o_conv_valid(o_conv_valid), .o_conv_data(o_conv_data), .i_conv_valid(i_conv_valid),
    .i_conv_result(i_conv_result), .o_res_we(o_res_we), .o_res_addr(o_res_addr),
    .o_res_wdata(o_res_wdata), .o_EOP(o_EOP), .o_overflow(o_overflow), .o_state(o_state)
  );

  // image RAM model, 1-cycle read latency
  logic [DW-1:0] img_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (o_img_we) img_mem[o_img_addr] <= o_img_wdata;
    if (o_img_re) i_img_rdata <= img_mem[o_img_addr];
  end

  // conv unit: echoes each accepted pixel 3 cycles later
  logic [2:0]    cv = '0;
  logic [DW-1:0] cd0 = '0, cd1 = '0, cd2 = '0;
  logic          force_cv = 1'b0;
  always @(posedge clk) begin
    cv  <= {cv[1:0], o_conv_valid};
    cd0 <= o_conv_data;
    cd1 <= cd0;
    cd2 <= cd1;
  end
  assign i_conv_valid  = cv[2] | force_cv;
  assign i_conv_result = force_cv ? 8'hEE : cd2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            re_cnt = 0, re_bad = 0, we_cnt = 0;
  logic [DW-1:0] conv_d[$];
  int            conv_c[$];
  int            res_a[$];
  logic [DW-1:0] res_d[$];
  int            res_c[$];

  always @(negedge clk) begin
    #3;
    if (o_img_re) begin
      re_cnt++;
      if (!i_conv_ready) re_bad++;
    end
    if (o_img_we) we_cnt++;
    if (o_conv_valid) begin
      conv_d.push_back(o_conv_data);
      conv_c.push_back(cyc);
    end
    if (o_res_we) begin
      res_a.push_back(int'(o_res_addr));
      res_d.push_back(o_res_wdata);
      res_c.push_back(cyc);
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_logs();
    re_cnt = 0; re_bad = 0; we_cnt = 0;
    conv_d.delete(); conv_c.delete();
    res_a.delete(); res_d.delete(); res_c.delete();
  endtask

  task automatic load_img(input int n, input int strobes, input int base);
    i_load = 1'b1;
    i_imgLength = AW'(n);
    tick();
    for (int k = 0; k < strobes; k++) begin
      i_valid = 1'b1; i_KNorIMG = 1'b1; i_pixel = DW'(base + k);
      tick();
    end
    i_valid = 1'b0;
    i_load = 1'b0;
    tick();
  endtask

  task automatic wait_eop(input bit toggle, output int at);
    at = -1;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (toggle) i_conv_ready = ~i_conv_ready;
      #1;
      if (o_EOP) begin
        at = cyc;
        break;
      end
    end
    chk("eop_seen", 64'(at >= 0), 64'd1);
  endtask

  typedef struct {
    logic          valid;
    logic          knorimg;
    logic [DW-1:0] pixel;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic          exp_ovf;
  } ld_vec_t;

  ld_vec_t       vecs[9];
  logic [DW-1:0] exp_px[4];
  int            at;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 8'd10, 1'b1, 10'd0, 8'd10, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'd99, 1'b0, 10'd0, 8'd0,  1'b0};
    vecs[2] = '{1'b1, 1'b1, 8'd20, 1'b1, 10'd1, 8'd20, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'd55, 1'b0, 10'd0, 8'd0,  1'b0};
    vecs[4] = '{1'b1, 1'b1, 8'd30, 1'b1, 10'd2, 8'd30, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 8'd40, 1'b1, 10'd3, 8'd40, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 8'd50, 1'b0, 10'd0, 8'd0,  1'b0};
    vecs[7] = '{1'b0, 1'b1, 8'd0,  1'b0, 10'd0, 8'd0,  1'b1};
    vecs[8] = '{1'b1, 1'b0, 8'd77, 1'b0, 10'd0, 8'd0,  1'b1};

    // reset state
    tick(); tick();
    #1;
    chk("reset_outputs", {o_img_we, o_img_re, o_img_addr, o_img_wdata, o_conv_valid, o_conv_data,
                          o_res_we, o_res_addr, o_res_wdata, o_EOP, o_overflow}, 64'd0);
    chk("reset_state", 64'(o_state), 64'd0);
    rst = 1'b0;
    tick();

    // run with nothing loaded goes straight to DONE
    clear_logs();
    i_run = 1'b1; i_conv_ready = 1'b1;
    tick(); #1;
    chk("empty_run_state", 64'(o_state), 64'd4);
    chk("empty_run_eop", 64'(o_EOP), 64'd1);
    i_run = 1'b0;
    tick();
    chk("empty_run_no_activity", 64'(re_cnt + we_cnt + conv_d.size() + res_a.size()), 64'd0);

    // load N=4 from DONE; EOP must drop on LOAD entry
    i_load = 1'b1; i_imgLength = 10'd4;
    tick(); #1;
    chk("load_entry_state", 64'(o_state), 64'd1);
    chk("load_entry_eop", 64'(o_EOP), 64'd0);
    for (int i = 0; i < 9; i++) begin
      i_valid = vecs[i].valid; i_KNorIMG = vecs[i].knorimg; i_pixel = vecs[i].pixel;
      #1;
      chk($sformatf("ld%0d_we", i), 64'(o_img_we), 64'(vecs[i].exp_we));
      chk($sformatf("ld%0d_addr", i), 64'(o_img_addr), 64'(vecs[i].exp_addr));
      chk($sformatf("ld%0d_wdata", i), 64'(o_img_wdata), 64'(vecs[i].exp_wdata));
      chk($sformatf("ld%0d_ovf", i), 64'(o_overflow), 64'(vecs[i].exp_ovf));
      tick();
    end
    i_valid = 1'b0;
    i_run = 1'b1;
    #1;
    chk("run_ignored_in_load", 64'(o_state), 64'd1);
    i_run = 1'b0; i_load = 1'b0;
    tick(); #1;
    chk("load_exit_state", 64'(o_state), 64'd0);

    // run N=4 with ready held high
    clear_logs();
    i_conv_ready = 1'b1; i_run = 1'b1;
    wait_eop(1'b0, at);
    exp_px = '{8'd10, 8'd20, 8'd30, 8'd40};
    chk("t4_conv_count", 64'(conv_d.size()), 64'd4);
    chk("t4_res_count", 64'(res_a.size()), 64'd4);
    chk("t4_reads", 64'(re_cnt), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < conv_d.size()) begin
        chk($sformatf("t4_conv_data%0d", i), 64'(conv_d[i]), 64'(exp_px[i]));
        chk($sformatf("t4_conv_cycle%0d", i), 64'(conv_c[i] - conv_c[0]), 64'(i));
      end
      if (i < res_a.size()) begin
        chk($sformatf("t4_res_addr%0d", i), 64'(res_a[i]), 64'(i));
        chk($sformatf("t4_res_data%0d", i), 64'(res_d[i]), 64'(exp_px[i]));
      end
    end
    if (res_c.size() == 4) chk("t4_eop_timing", 64'(at - res_c[3]), 64'd1);
    i_run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk($sformatf("t4_eop_hold%0d", i), 64'({o_state, o_EOP}), 64'({3'd4, 1'b1}));
    end
    force_cv = 1'b1;
    #1;
    chk("done_ignores_result", 64'(o_res_we), 64'd0);
    tick();
    force_cv = 1'b0;

    // ready toggling 1,0,1,0...: reads only when ready, order preserved
    load_img(4, 4, 5);
    #1;
    chk("t5_eop_cleared", 64'(o_EOP), 64'd0);
    clear_logs();
    i_conv_ready = 1'b0; i_run = 1'b1;
    wait_eop(1'b1, at);
    i_run = 1'b0;
    chk("t5_no_read_unready", 64'(re_bad), 64'd0);
    chk("t5_reads", 64'(re_cnt), 64'd4);
    chk("t5_conv_count", 64'(conv_d.size()), 64'd4);
    chk("t5_res_count", 64'(res_a.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < conv_d.size()) chk($sformatf("t5_conv_data%0d", i), 64'(conv_d[i]), 64'(5 + i));
      if (i < res_a.size()) chk($sformatf("t5_res%0d", i), 64'({res_a[i], 24'(res_d[i])}),
                                 64'({i, 24'(5 + i)}));
    end
    tick();

    // reset in the middle of RUN with N=5, rd_cnt=3 (and overflow set)
    load_img(5, 6, 100);
    #1;
    chk("t1_overflow_set", 64'(o_overflow), 64'd1);
    i_conv_ready = 1'b1; i_run = 1'b1;
    tick(); tick(); tick(); tick();
    #1;
    chk("t1_mid_run_state", 64'(o_state), 64'd2);
    chk("t1_mid_run_addr", 64'({o_img_re, o_img_addr}), 64'({1'b1, 10'd3}));
    rst = 1'b1;
    tick(); #1;
    chk("t1_reset_outputs", {o_img_we, o_img_re, o_img_addr, o_img_wdata, o_conv_valid, o_conv_data,
                             o_res_we, o_res_addr, o_res_wdata, o_EOP, o_overflow}, 64'd0);
    chk("t1_reset_state", 64'(o_state), 64'd0);
    rst = 1'b0; i_run = 1'b0; i_conv_ready = 1'b0;
    tick();
    clear_logs();
    i_run = 1'b1; i_conv_ready = 1'b1;
    tick(); #1;
    chk("t1_wr_cleared_done", 64'({o_state, o_EOP}), 64'({3'd4, 1'b1}));
    i_run = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t1_no_activity", 64'(re_cnt + we_cnt + conv_d.size() + res_a.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
